// File: rtl/demux7_deserializer_if.sv
// ============================================================================
// Module   : demux7_deserializer_if
// Brief    : Strobe/data/mode inputs and assembled-word outputs of the 1:7 demux.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface demux7_deserializer_if;
    logic       strobe;
    logic       data_in;
    logic [2:0] addr;
    logic       auto;
    logic       clear;
    logic [6:0] out;
    logic       done;
    logic [2:0] bit_count;

    modport master (
        output strobe, data_in, addr, auto, clear,
        input  out, done, bit_count
    );

    modport slave (
        input  strobe, data_in, addr, auto, clear,
        output out, done, bit_count
    );
endinterface

`default_nettype wire

// File: rtl/demux7_deserializer.sv
// ============================================================================
// Module   : demux7_deserializer
// Brief    : Sequential 1:7 demux; addressed bit writes or LSB-first frame assembly.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux7_deserializer (
    input  wire                    clk,
    input  wire                    reset,
    demux7_deserializer_if.slave   bus
);
    localparam logic [2:0] c_PTR_LAST = 3'd6;
    localparam logic [2:0] c_ADDR_ALT = 3'd7;

    logic [6:0] out_q,    out_d;
    logic [6:0] shadow_q, shadow_d;
    logic [2:0] ptr_q,    ptr_d;
    logic       done_q,   done_d;

    logic [2:0] w_addr_idx;
    logic [2:0] w_ptr_eff;

    // Address 7 aliases bit 0, mirroring the default arm of the transmit mux.
    assign w_addr_idx = (bus.addr == c_ADDR_ALT) ? 3'd0 : bus.addr;
    assign w_ptr_eff  = (ptr_q == c_ADDR_ALT) ? 3'd0 : ptr_q;

    always_comb begin
        out_d    = out_q;
        shadow_d = shadow_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;

        if (bus.clear) begin
            ptr_d    = 3'd0;
            shadow_d = 7'd0;
        end else if (!bus.auto) begin
            ptr_d = 3'd0;
            if (bus.strobe) begin
                out_d[w_addr_idx] = bus.data_in;
            end
        end else if (bus.strobe) begin
            if (w_ptr_eff == c_PTR_LAST) begin
                out_d    = {bus.data_in, shadow_q[5:0]};
                shadow_d = 7'd0;
                ptr_d    = 3'd0;
                done_d   = 1'b1;
            end else begin
                shadow_d[w_ptr_eff] = bus.data_in;
                ptr_d               = w_ptr_eff + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= 7'd0;
            shadow_q <= 7'd0;
            ptr_q    <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            out_q    <= out_d;
            shadow_q <= shadow_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.bit_count = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_demux7_deserializer.sv
// ============================================================================
// Module   : tb_demux7_deserializer
// Brief    : Directed and random stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux7_deserializer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    demux7_deserializer_if bus ();

    demux7_deserializer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the latched word plus the bits received so far in the current frame.
    logic [6:0] m_out  = 7'd0;
    logic       m_done = 1'b0;
    bit         m_q[$];

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic rst, input logic st, input logic d,
                        input logic [2:0] a, input logic au, input logic cl);
        int idx;
        @(negedge clk);
        reset       = rst;
        bus.strobe  = st;
        bus.data_in = d;
        bus.addr    = a;
        bus.auto    = au;
        bus.clear   = cl;
        @(posedge clk);
        m_done = 1'b0;
        if (rst) begin
            m_out = 7'd0;
            m_q.delete();
        end else if (cl) begin
            m_q.delete();
        end else if (!au) begin
            m_q.delete();
            if (st) begin
                idx = (a == 3'd7) ? 0 : int'(a);
                m_out[idx] = d;
            end
        end else if (st) begin
            m_q.push_back(d);
            if (m_q.size() == 7) begin
                for (int i = 0; i < 7; i++) m_out[i] = m_q[i];
                m_done = 1'b1;
                m_q.delete();
            end
        end
        #1;
        check_eq("out", bus.out, m_out);
        check_eq("done", {6'd0, bus.done}, {6'd0, m_done});
        check_eq("bit_count", {4'd0, bus.bit_count}, 7'(m_q.size()));
    endtask

    task automatic send_frame(input logic [6:0] w, input bit gapped);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, w[i], 3'd0, 1'b1, 1'b0);
            if (gapped) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [6:0] bits;
        logic       au;
        reset       = 1'b1;
        bus.strobe  = 1'b0;
        bus.data_in = 1'b0;
        bus.addr    = 3'd0;
        bus.auto    = 1'b0;
        bus.clear   = 1'b0;

        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
        check_eq("reset_out", bus.out, 7'd0);

        // Addressed writes
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
        check_eq("addr_word", bus.out, 7'b1010101);
        step(1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
        check_eq("addr7_alias", bus.out, 7'b1010100);

        // LSB-first auto frame
        bits = 7'b1001101;
        send_frame(bits, 1'b0);
        check_eq("auto_frame", bus.out, 7'b1001101);

        // Gapped frame, then back-to-back continuous frames
        send_frame(7'h55, 1'b1);
        check_eq("gapped_frame", bus.out, 7'h55);
        send_frame(7'h2A, 1'b0);
        check_eq("b2b_frame", bus.out, 7'h2A);
        send_frame(7'h13, 1'b0);

        // Clear mid-frame discards the coincident strobe
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
        check_eq("clear_ptr", {4'd0, bus.bit_count}, 7'd0);
        send_frame(7'h3C, 1'b0);
        check_eq("post_clear_frame", bus.out, 7'h3C);

        // Mode switch abandons the partial frame
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        check_eq("switch_out", bus.out, 7'h3C);
        send_frame(7'h41, 1'b0);

        // Reset mid-frame
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        check_eq("midreset_out", bus.out, 7'd0);

        // Random traffic with sticky mode
        au = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) au = ~au;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 3'($urandom),
                 au,
                 ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
